// File: rtl/seqdet_pkg.sv
// Shared types and constants for the parameterised serial sequence detector.
// Holds the FSM state enum, default widths and the legal pattern-width bounds.
package seqdet_pkg;

  localparam int DEF_PAT_W = 8;
  localparam int DEF_CNT_W = 16;
  localparam int MIN_PAT_W = 2;
  localparam int MAX_PAT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2
  } state_t;

  // A length is usable only if it selects at least one bit and fits the history.
  function automatic logic lenLegal(input int len, input int maxLen);
    return (len >= 1) && (len <= maxLen);
  endfunction

endpackage

// File: rtl/seqdet_shift_match.sv
// History shift register, saturating fill counter and length-masked pattern compare.
// match_o is combinational and reflects the history as it will be after this edge.
module seqdet_shift_match
  import seqdet_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             shift_i,
  input  logic             bit_i,
  input  logic             restart_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             match_o
);

  logic [PAT_W-1:0] history_q, history_d, histNext, mask;
  logic [LEN_W-1:0] fill_q, fill_d, fillNext;

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len_i));
    end

    histNext = {history_q[PAT_W-2:0], bit_i};
    fillNext = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + LEN_W'(1);

    match_o = shift_i && (fillNext >= len_i) &&
              (((histNext ^ pattern_i) & mask) == '0);

    history_d = history_q;
    fill_d    = fill_q;
    if (clear_i) begin
      history_d = '0;
      fill_d    = '0;
    end else if (shift_i) begin
      history_d = histNext;
      // Non-overlapping mode forgets the consumed bits by emptying the fill count.
      fill_d    = (match_o && restart_i) ? '0 : fillNext;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      history_q <= '0;
      fill_q    <= '0;
    end else begin
      history_q <= history_d;
      fill_q    <= fill_d;
    end
  end

endmodule

// File: rtl/sequence_detector_param.sv
// Configurable serial pattern detector: FSM, configuration latch and match counter.
// Define SEQDET_COUNT_EN to build the match counter; otherwise match_count reads 0.
module sequence_detector_param
  import seqdet_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       sequence_in,
  input  logic                       in_valid,
  input  logic                       cfg_load,
  input  logic [PAT_W-1:0]           pattern,
  input  logic [$clog2(PAT_W+1)-1:0] pat_len,
  input  logic                       overlap_en,
  output logic                       detector_out,
  output logic                       armed,
  output logic                       cfg_err,
  output logic [CNT_W-1:0]           match_count
);

  localparam int LEN_W = $clog2(PAT_W + 1);

  if (PAT_W < MIN_PAT_W || PAT_W > MAX_PAT_W) begin : gBadPatW
    $error("sequence_detector_param: PAT_W outside supported range");
  end

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pattern_q;
  logic [LEN_W-1:0] len_q;
  logic             overlap_q;
  logic             armed_q;
  logic             cfgErr_q;
  logic             loadLegal;
  logic             shiftEn;
  logic             matchHit;

  // A load in the same cycle as a data bit wins and the bit is dropped.
  assign loadLegal = cfg_load && lenLegal(int'(pat_len), PAT_W);
  assign shiftEn   = in_valid && !cfg_load && (state_q != IDLE);

  seqdet_shift_match #(
    .PAT_W(PAT_W),
    .LEN_W(LEN_W)
  ) uShiftMatch (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear_i  (loadLegal),
    .shift_i  (shiftEn),
    .bit_i    (sequence_in),
    .restart_i(!overlap_q),
    .pattern_i(pattern_q),
    .len_i    (len_q),
    .match_o  (matchHit)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cfg_load) begin
      state_d = loadLegal ? RUN : IDLE;
    end else begin
      case (state_q)
        IDLE:     state_d = IDLE;
        RUN, HIT: state_d = (in_valid && matchHit) ? HIT : RUN;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    detector_out = (state_q == HIT);
    armed        = armed_q;
    cfg_err      = cfgErr_q;
  end

  // An illegal load keeps the previous pattern but disarms until a legal one arrives.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      armed_q   <= 1'b0;
      cfgErr_q  <= 1'b0;
    end else if (cfg_load) begin
      if (loadLegal) begin
        pattern_q <= pattern;
        len_q     <= pat_len;
        overlap_q <= overlap_en;
        armed_q   <= 1'b1;
        cfgErr_q  <= 1'b0;
      end else begin
        armed_q   <= 1'b0;
        cfgErr_q  <= 1'b1;
      end
    end
  end

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (loadLegal) begin
      count_d = '0;
    end else if (matchHit && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign match_count = count_q;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_sequence_detector_param.sv
// Directed, table-driven bench for sequence_detector_param (PAT_W=8, CNT_W=2).
// Expected counts follow SEQDET_COUNT_EN: real values when defined, 0 otherwise.
module tb_sequence_detector_param;

  localparam int PAT_W = 8;
  localparam int CNT_W = 2;
  localparam int LEN_W = 4;

  typedef struct {
    logic             load;
    logic [PAT_W-1:0] pat;
    logic [LEN_W-1:0] len;
    logic             ov;
    logic             valid;
    logic             bitIn;
    logic             expDet;
    logic             expArmed;
    logic             expErr;
    int               expCnt;
  } vec_t;

  logic             clock;
  logic             reset_n;
  logic             sequence_in;
  logic             in_valid;
  logic             cfg_load;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic             overlap_en;
  logic             detector_out;
  logic             armed;
  logic             cfg_err;
  logic [CNT_W-1:0] match_count;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  sequence_detector_param #(
    .PAT_W(PAT_W),
    .CNT_W(CNT_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .sequence_in (sequence_in),
    .in_valid    (in_valid),
    .cfg_load    (cfg_load),
    .pattern     (pattern),
    .pat_len     (pat_len),
    .overlap_en  (overlap_en),
    .detector_out(detector_out),
    .armed       (armed),
    .cfg_err     (cfg_err),
    .match_count (match_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int expCount(input int c);
`ifdef SEQDET_COUNT_EN
    return c;
`else
    return 0 * c;
`endif
  endfunction

  function automatic vec_t mk(input logic load, input logic [PAT_W-1:0] pat, input int len,
                              input logic ov, input logic valid, input logic b,
                              input logic det, input logic arm, input logic err, input int cnt);
    vec_t v;
    v.load = load;  v.pat = pat;   v.len = LEN_W'(len); v.ov = ov;
    v.valid = valid; v.bitIn = b;  v.expDet = det;      v.expArmed = arm;
    v.expErr = err; v.expCnt = cnt;
    return v;
  endfunction

  // Legal or illegal load; detector_out is always low the cycle after a load.
  function automatic vec_t ld(input logic [PAT_W-1:0] pat, input int len, input logic ov,
                              input logic arm, input logic err, input int cnt);
    return mk(1'b1, pat, len, ov, 1'b0, 1'b0, 1'b0, arm, err, cnt);
  endfunction

  function automatic vec_t dat(input logic b, input logic det, input logic arm,
                               input logic err, input int cnt);
    return mk(1'b0, '0, 0, 1'b0, 1'b1, b, det, arm, err, cnt);
  endfunction

  function automatic vec_t gap(input logic det, input logic arm, input logic err, input int cnt);
    return mk(1'b0, '0, 0, 1'b0, 1'b0, 1'b1, det, arm, err, cnt);
  endfunction

  task automatic applyStimulus(input vec_t v);
    cfg_load    = v.load;
    pattern     = v.pat;
    pat_len     = v.len;
    overlap_en  = v.ov;
    in_valid    = v.valid;
    sequence_in = v.bitIn;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic det, input logic arm,
                          input logic err, input int cnt);
    checkOutput({tag, " det"},   32'(detector_out), 32'(det));
    checkOutput({tag, " armed"}, 32'(armed),        32'(arm));
    checkOutput({tag, " err"},   32'(cfg_err),      32'(err));
    checkOutput({tag, " cnt"},   32'(match_count),  32'(expCount(cnt)));
  endtask

  initial begin
    reset_n = 1'b0; sequence_in = 1'b1; in_valid = 1'b1; cfg_load = 1'b0;
    pattern = '0;   pat_len = '0;       overlap_en = 1'b0;

    // Reset state
    repeat (2) begin
      @(posedge clock);
      #1;
      checkAll("reset", 1'b0, 1'b0, 1'b0, 0);
    end
    reset_n = 1'b1;

    // 1011 overlapping: pulses after bits 4 and 7
    vecs.push_back(ld(8'h0B, 4, 1'b1, 1, 0, 0));
    vecs.push_back(dat(1, 0, 1, 0, 0));
    vecs.push_back(dat(0, 0, 1, 0, 0));
    vecs.push_back(dat(1, 0, 1, 0, 0));
    vecs.push_back(dat(1, 1, 1, 0, 1));
    vecs.push_back(dat(0, 0, 1, 0, 1));
    vecs.push_back(dat(1, 0, 1, 0, 1));
    vecs.push_back(dat(1, 1, 1, 0, 2));
    vecs.push_back(gap(0, 1, 0, 2));
    // 1011 non-overlapping: single pulse
    vecs.push_back(ld(8'h0B, 4, 1'b0, 1, 0, 0));
    vecs.push_back(dat(1, 0, 1, 0, 0));
    vecs.push_back(dat(0, 0, 1, 0, 0));
    vecs.push_back(dat(1, 0, 1, 0, 0));
    vecs.push_back(dat(1, 1, 1, 0, 1));
    vecs.push_back(dat(0, 0, 1, 0, 1));
    vecs.push_back(dat(1, 0, 1, 0, 1));
    vecs.push_back(dat(1, 0, 1, 0, 1));
    // 2-bit 01, then 11 held in HIT for two cycles
    vecs.push_back(ld(8'h01, 2, 1'b1, 1, 0, 0));
    vecs.push_back(dat(0, 0, 1, 0, 0));
    vecs.push_back(dat(1, 1, 1, 0, 1));
    vecs.push_back(dat(0, 0, 1, 0, 1));
    vecs.push_back(dat(1, 1, 1, 0, 2));
    vecs.push_back(ld(8'h03, 2, 1'b1, 1, 0, 0));
    vecs.push_back(dat(1, 0, 1, 0, 0));
    vecs.push_back(dat(1, 1, 1, 0, 1));
    vecs.push_back(dat(1, 1, 1, 0, 2));
    vecs.push_back(gap(0, 1, 0, 2));
    // Illegal lengths 0 and PAT_W+1: disarmed, data ignored, count kept
    vecs.push_back(ld(8'h03, 0, 1'b1, 0, 1, 2));
    vecs.push_back(dat(1, 0, 0, 1, 2));
    vecs.push_back(dat(1, 0, 0, 1, 2));
    vecs.push_back(ld(8'h03, PAT_W + 1, 1'b1, 0, 1, 2));
    vecs.push_back(dat(1, 0, 0, 1, 2));
    vecs.push_back(dat(1, 0, 0, 1, 2));
    // Legal load with a simultaneous data bit: the bit is discarded
    vecs.push_back(mk(1'b1, 8'h03, 2, 1'b1, 1'b1, 1'b1, 0, 1, 0, 0));
    vecs.push_back(dat(1, 0, 1, 0, 0));
    vecs.push_back(dat(1, 1, 1, 0, 1));
    // Full-width pattern with an invalid cycle in the middle
    vecs.push_back(ld(8'hA5, 8, 1'b0, 1, 0, 0));
    vecs.push_back(dat(1, 0, 1, 0, 0));
    vecs.push_back(dat(0, 0, 1, 0, 0));
    vecs.push_back(dat(1, 0, 1, 0, 0));
    vecs.push_back(dat(0, 0, 1, 0, 0));
    vecs.push_back(gap(0, 1, 0, 0));
    vecs.push_back(dat(0, 0, 1, 0, 0));
    vecs.push_back(dat(1, 0, 1, 0, 0));
    vecs.push_back(dat(0, 0, 1, 0, 0));
    vecs.push_back(dat(1, 1, 1, 0, 1));
    vecs.push_back(gap(0, 1, 0, 1));
    // Length 1, five back-to-back matches: counter saturates at 3
    vecs.push_back(ld(8'h01, 1, 1'b1, 1, 0, 0));
    vecs.push_back(dat(1, 1, 1, 0, 1));
    vecs.push_back(dat(1, 1, 1, 0, 2));
    vecs.push_back(dat(1, 1, 1, 0, 3));
    vecs.push_back(dat(1, 1, 1, 0, 3));
    vecs.push_back(dat(1, 1, 1, 0, 3));
    vecs.push_back(gap(0, 1, 0, 3));
    vecs.push_back(dat(0, 0, 1, 0, 3));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkAll($sformatf("row%0d", i), vecs[i].expDet, vecs[i].expArmed,
               vecs[i].expErr, vecs[i].expCnt);
    end

    // Reset after 3 of 4 bits, overriding an illegal load and a data bit
    applyStimulus(ld(8'h0B, 0, 1'b1, 0, 1, 3));
    checkAll("preRstErr", 1'b0, 1'b0, 1'b1, 3);
    applyStimulus(ld(8'h0B, 4, 1'b1, 1, 0, 0));
    applyStimulus(dat(1, 0, 1, 0, 0));
    applyStimulus(dat(0, 0, 1, 0, 0));
    applyStimulus(dat(1, 0, 1, 0, 0));
    checkAll("preRst", 1'b0, 1'b1, 1'b0, 0);
    reset_n = 1'b0;
    applyStimulus(mk(1'b1, 8'h0B, 0, 1'b1, 1'b1, 1'b1, 0, 0, 0, 0));
    checkAll("midRst", 1'b0, 1'b0, 1'b0, 0);
    reset_n = 1'b1;
    applyStimulus(dat(1, 0, 0, 0, 0));
    checkAll("postRst4th", 1'b0, 1'b0, 1'b0, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(dat(1, 0, 0, 0, 0));
      checkAll($sformatf("postRstIdle%0d", k), 1'b0, 1'b0, 1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequence_detector_param.md
SEQUENCE_DETECTOR_PARAM -- requirements
Module: sequence_detector_param

Interface
REQ-001 SHALL have parameter PAT_W, default 8, meaning the maximum pattern length in bits (range 2..32).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the match counter width.
REQ-003 SHALL have port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, a synchronous active-low reset.
REQ-005 SHALL have port sequence_in, input, 1, the serial data bit.
REQ-006 SHALL have port in_valid, input, 1, which qualifies sequence_in; the bit is ignored when in_valid is low.
REQ-007 SHALL have port cfg_load, input, 1, a one-cycle configuration strobe.
REQ-008 SHALL have port pattern, input, PAT_W, the target pattern; bit [pat_len-1] is the oldest bit and bit [0] is the newest.
REQ-009 SHALL have port pat_len, input, $clog2(PAT_W+1), the active pattern length.
REQ-010 SHALL have port overlap_en, input, 1; 1 allows overlapping matches and 0 restarts after a match.
REQ-011 SHALL have port detector_out, output, 1, the registered Moore match pulse.
REQ-012 SHALL have port armed, output, 1, set high when a valid configuration is loaded.
REQ-013 SHALL have port cfg_err, output, 1, a sticky flag for an illegal pat_len.
REQ-014 SHALL have port match_count, output, CNT_W, the number of matches since reset or load.

Function
REQ-015 SHALL implement an FSM with states IDLE (unconfigured), RUN and HIT; detector_out SHALL be 1 only in HIT.
REQ-016 On a cfg_load with 1<=pat_len<=PAT_W, SHALL latch pattern, pat_len and overlap_en, clear the history, fill count and match_count, clear cfg_err, and enter RUN.
REQ-017 On a cfg_load with pat_len==0 or pat_len>PAT_W, SHALL enter IDLE, set cfg_err, and drop armed.
REQ-018 cfg_load SHALL take priority over in_valid in the same cycle; that data bit SHALL be discarded.
REQ-019 In RUN or HIT with in_valid=1, SHALL shift sequence_in into the history and increment the fill count, saturating at PAT_W.
REQ-020 A match SHALL occur when the updated fill count is >= len and the updated history[len-1:0] equals pattern[len-1:0].
REQ-021 On a match, the next state SHALL be HIT; otherwise it SHALL be RUN.
REQ-022 Latency SHALL be detector_out high exactly one cycle after the clock edge that accepts the completing bit, for one cycle per match.
REQ-023 Back-to-back matches SHALL keep the FSM in HIT with detector_out continuously high.
REQ-024 With overlap_en=0, a match SHALL reset the fill count to 0, so the next match needs len new bits.
REQ-025 With overlap_en=1, the history SHALL be retained after a match.
REQ-026 In HIT with in_valid=0, the FSM SHALL return to RUN.
REQ-027 In IDLE, the FSM SHALL ignore in_valid.
REQ-028 match_count SHALL increment on each match and saturate at all-ones without wrapping.

Reset
REQ-029 When reset_n=0 at a clock edge, SHALL set state=IDLE, history=0, fill=0, detector_out=0, armed=0, cfg_err=0, match_count=0 and stored config=0.
REQ-030 Reset SHALL override cfg_load and in_valid, and SHALL abort any partial match immediately.

Configuration
REQ-031 Macro SEQDET_COUNT_EN SHALL gate the counter feature.
REQ-032 When SEQDET_COUNT_EN is defined, match_count SHALL behave per REQ-014 and REQ-028.
REQ-033 When SEQDET_COUNT_EN is undefined, match_count SHALL be tied to 0, no counter flops SHALL exist, and the port list SHALL be unchanged.

Structure
REQ-034 Package seqdet_pkg SHALL hold the state enum (IDLE, RUN, HIT), the PAT_W and CNT_W defaults, and the legal PAT_W bounds.
REQ-035 Sub-module seqdet_shift_match SHALL hold the history register, the fill counter and the masked compare, producing a match strobe; the FSM, config latch and counter SHALL be in the top level.

Verification
REQ-036 Scenario: pattern=4'b1011, len=4, overlap=1, bits 1,0,1,1,0,1,1 -> detector_out pulses after bit 4 and after bit 7, and match_count=2.
REQ-037 Scenario: same stimulus as REQ-036 with overlap=0 -> a single pulse after bit 4, and match_count=1.
REQ-038 Scenario: pattern=1 (binary), len=2 (pattern 01 read as len-bit value 2'b01), overlap=1, bits 0,1,0,1 -> pulses after bits 2 and 4; then pattern=2'b11 with bits 1,1,1 -> HIT held for 2 consecutive cycles.
REQ-039 Scenario: cfg_load with pat_len=0, then with pat_len=PAT_W+1 -> cfg_err=1, armed=0, and in_valid bits produce no pulse; a legal load then clears cfg_err.
REQ-040 Scenario: reset_n low after 3 of 4 pattern bits, then the 4th bit -> no pulse, state IDLE, all outputs 0.
REQ-041 Scenario: with CNT_W=2, apply 5 matches -> match_count saturates at 3; in a build without SEQDET_COUNT_EN, match_count stays 0 throughout.
